keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Front end that produces the microwave controller's keypad-side inputs from a physical 4x4 matrix keypad.
- Drives the keypad columns one at a time and samples the rows.
- Debounces the decoded key over whole scans.
- Outputs the controller's `keys[9:0]` bus (one-hot, held while pressed) plus active-low `startn`, `stopn` and `clearn`, each held while its key is pressed.

Parameters:
- COL_HOLD, 4: clock cycles each column stays driven; rows are sampled on the last cycle. Minimum 3, to cover the 2-flop synchronizer.
- DEBOUNCE_SCANS, 2: consecutive identical full-scan results required before the stable key changes. Minimum 1.

Ports:
- clock  in  1  system clock, 100 Hz in the microwave system.
- reset  in  1  asynchronous, active-high.
- row_n  in  4  keypad rows, active-low, pulled up externally, asynchronous.
- col_n  out  4  keypad column drive, active-low, exactly one bit low at any time.
- keys  out  10  one-hot digit bus; bit d = digit d held; all-zero when no digit is held.
- startn  out  1  low while 'A' (start) is the stable key.
- stopn  out  1  low while 'B' (stop) is the stable key.
- clearn  out  1  low while 'C' (clear) is the stable key.
- key_strobe  out  1  one-cycle pulse when the stable key changes to any valid key.

Behaviour:
- Key map, [row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
  - '*', '#' and 'D' are ignored and decode as no-key.
- Reset values:
  - col_n = 4'b1110 (column 0); column index = 0; hold counter = 0.
  - keys = 0; startn = stopn = clearn = 1; key_strobe = 0.
  - Synchronizer flops = 4'b1111; scan accumulator = NONE; previous scan code = NONE; stable code = NONE; debounce count = 0.
- Reset mid-scan aborts the scan immediately, including while a key is held; outputs return to idle asynchronously.
- Synchronizer: row_n passes through 2 flops before use.
- Scan:
  - The hold counter counts 0..COL_HOLD-1 per column.
  - On the sampling edge (counter = COL_HOLD-1), the synchronized rows are decoded for the current column and merged into the scan accumulator.
  - Then the column index advances mod 4 and col_n rotates: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Full scan period = 4*COL_HOLD cycles (16 at default).
- Accumulator codes: NONE, 0-9, START, STOP, CLEAR, MULTI.
  - One low row in a column while the accumulator is NONE: the accumulator takes that key.
  - More than one low row in a column, or a second key in a later column: the accumulator becomes MULTI.
  - Ignored keys contribute nothing.
- End of scan (column 3 sampling edge):
  - The scan result (MULTI is folded to NONE) is compared with the previous scan code.
  - If equal: debounce count saturates at DEBOUNCE_SCANS.
  - Otherwise the count resets to 1.
  - The previous scan code takes the result; the accumulator is cleared to NONE.
- Stable update: on the clock edge after an end-of-scan edge, if count = DEBOUNCE_SCANS and the result differs from the stable code, the stable code takes the result.
  - If the new stable code is not NONE, key_strobe = 1 for that cycle only.
- Outputs are registered decodes of the stable code and update on the edge after the stable code changes.
  - A digit key sets exactly one keys bit.
  - Non-digit stable codes give keys = 0.
- Latency (default parameters, clean press held from cycle t): outputs assert no later than t + 2 + (DEBOUNCE_SCANS+1)*16 + 2 cycles. Release is symmetric; the stable code returns to NONE.
- Direct key-to-key change without an intervening NONE: the stable code switches directly and key_strobe pulses once.
- Bounce shorter than one scan never produces more than one key_strobe per press when DEBOUNCE_SCANS ≥ 2.
- At most one of {keys≠0, startn=0, stopn=0, clearn=0} holds at any time.

Decomposition:
- Shared package `keypad_pkg`:
  - key code enum, 4-bit: NONE=15, 0-9 = digit value, START=10, STOP=11, CLEAR=12, MULTI=13.
  - constant key-map function (row, col) -> code.
  - one-hot digit decode function.
- Sub-module `row_sync`: 2-flop synchronizer, 4 bits wide, reset to all-ones.
- Scan counter, accumulator and debounce live in keypad_scanner.

Test Plan:
- Reset asserted mid-scan while '5' is held -> col_n=1110, keys=0, startn/stopn/clearn=1 immediately; no key_strobe.
- Hold '5' (row1 low when col_n[1]=0) for 80 cycles -> keys=10'b0000100000 within 54 cycles; exactly one key_strobe; keys=0 within 54 cycles after release.
- Press 1, release, 0, release, 5, release (each 60 cycles held, 60 released) -> keys shows 0000000010, then 0000000001, then 0000100000; three key_strobes total.
- Hold 'A' for 60 cycles -> startn low for the duration, keys=0; same for 'B' on stopn and 'C' on clearn.
- '3' and '7' held together -> MULTI; outputs stay idle; no key_strobe.
- '8' with 6-cycle bounce glitches for the first 20 cycles, then stable -> one key_strobe, keys=10'b0100000000; '*', '#', 'D' held -> no output change.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_pkg                                                           |
// | Key codes, matrix key map and digit decode for the keypad scanner.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package keypad_pkg;

  typedef enum logic [3:0] {
    KC_0     = 4'd0,
    KC_1     = 4'd1,
    KC_2     = 4'd2,
    KC_3     = 4'd3,
    KC_4     = 4'd4,
    KC_5     = 4'd5,
    KC_6     = 4'd6,
    KC_7     = 4'd7,
    KC_8     = 4'd8,
    KC_9     = 4'd9,
    KC_START = 4'd10,
    KC_STOP  = 4'd11,
    KC_CLEAR = 4'd12,
    KC_MULTI = 4'd13,
    KC_NONE  = 4'd15
  } key_code_e;

  // '*', '#' and 'D' fall through to NONE so they never reach the accumulator.
  function automatic key_code_e key_map(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'd0:    key_map = KC_1;
      4'd1:    key_map = KC_2;
      4'd2:    key_map = KC_3;
      4'd3:    key_map = KC_START;
      4'd4:    key_map = KC_4;
      4'd5:    key_map = KC_5;
      4'd6:    key_map = KC_6;
      4'd7:    key_map = KC_STOP;
      4'd8:    key_map = KC_7;
      4'd9:    key_map = KC_8;
      4'd10:   key_map = KC_9;
      4'd11:   key_map = KC_CLEAR;
      4'd13:   key_map = KC_0;
      default: key_map = KC_NONE;
    endcase
  endfunction

  function automatic logic [9:0] digit_onehot(input key_code_e code);
    logic [3:0] v;
    v = code;
    digit_onehot = '0;
    if (v < 4'd10) digit_onehot = 10'd1 << v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/row_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | row_sync                                                             |
// | Two-flop synchronizer for the asynchronous active-low keypad rows.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module row_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] d_n,
  output logic [3:0] q_n
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_n;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_n = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_scanner                                                       |
// | 4x4 matrix scan, whole-scan debounce and controller key outputs.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COL_HOLD       = 4,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [9:0] keys,
  output logic       startn,
  output logic       stopn,
  output logic       clearn,
  output logic       key_strobe
);

  localparam int HW = (COL_HOLD > 1) ? $clog2(COL_HOLD) : 1;
  localparam int DW = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(COL_HOLD - 1);
  localparam logic [DW-1:0] CNT_MAX   = DW'(DEBOUNCE_SCANS);

  logic [3:0] rows_s;

  row_sync u_row_sync (
    .clock (clock),
    .reset (reset),
    .d_n   (row_n),
    .q_n   (rows_s)
  );

  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    col_n_q, col_n_d;
  key_code_e     acc_q, acc_d;
  key_code_e     prev_q, prev_d;
  key_code_e     stable_q, stable_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          eos_q, eos_d;
  logic          strobe_q, strobe_d;
  logic [9:0]    keys_q, keys_d;
  logic          startn_q, startn_d;
  logic          stopn_q, stopn_d;
  logic          clearn_q, clearn_d;

  key_code_e col_code, merged, result;
  logic      sample, eos;

  always_comb begin
    col_code = KC_NONE;
    for (int r = 0; r < 4; r++) begin
      if (!rows_s[r]) col_code = key_map(2'(r), col_idx_q);
    end
    if ($countones(~rows_s) > 1) col_code = KC_MULTI;

    // A second distinct key anywhere in the scan poisons the whole scan.
    merged = acc_q;
    if (col_code == KC_MULTI) merged = KC_MULTI;
    else if (col_code != KC_NONE) merged = (acc_q == KC_NONE) ? col_code : KC_MULTI;

    sample = (hold_q == HOLD_LAST);
    eos    = sample && (col_idx_q == 2'd3);
    result = (merged == KC_MULTI) ? KC_NONE : merged;

    hold_d    = sample ? '0 : hold_q + 1'b1;
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
    col_n_d   = sample ? {col_n_q[2:0], col_n_q[3]} : col_n_q;
    acc_d     = sample ? (eos ? KC_NONE : merged) : acc_q;
    prev_d    = eos ? result : prev_q;
    eos_d     = eos;

    cnt_d = cnt_q;
    if (eos) begin
      if (result == prev_q) cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + DW'(1);
      else                  cnt_d = DW'(1);
    end

    stable_d = stable_q;
    strobe_d = 1'b0;
    if (eos_q && (cnt_q == CNT_MAX) && (prev_q != stable_q)) begin
      stable_d = prev_q;
      strobe_d = (prev_q != KC_NONE);
    end

    keys_d   = digit_onehot(stable_q);
    startn_d = (stable_q != KC_START);
    stopn_d  = (stable_q != KC_STOP);
    clearn_d = (stable_q != KC_CLEAR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q    <= '0;
      col_idx_q <= 2'd0;
      col_n_q   <= 4'b1110;
      acc_q     <= KC_NONE;
      prev_q    <= KC_NONE;
      stable_q  <= KC_NONE;
      cnt_q     <= '0;
      eos_q     <= 1'b0;
      strobe_q  <= 1'b0;
      keys_q    <= '0;
      startn_q  <= 1'b1;
      stopn_q   <= 1'b1;
      clearn_q  <= 1'b1;
    end else begin
      hold_q    <= hold_d;
      col_idx_q <= col_idx_d;
      col_n_q   <= col_n_d;
      acc_q     <= acc_d;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      eos_q     <= eos_d;
      strobe_q  <= strobe_d;
      keys_q    <= keys_d;
      startn_q  <= startn_d;
      stopn_q   <= stopn_d;
      clearn_q  <= clearn_d;
    end
  end

  assign col_n      = col_n_q;
  assign keys       = keys_q;
  assign startn     = startn_q;
  assign stopn      = stopn_q;
  assign clearn     = clearn_q;
  assign key_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_keypad_scanner                                                    |
// | Directed bench with a matrix keypad model for keypad_scanner.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_keypad_scanner;

  logic        clock;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [9:0]  keys;
  logic        startn, stopn, clearn, key_strobe;

  // Pressed switches, bit index = row*4 + col.
  logic [15:0] pressed;
  logic [12:0] obs;
  int          n_checks, n_fails;
  int          strobes, excl_bad;

  localparam logic [12:0] IDLE = {10'b0, 3'b111};

  keypad_scanner #(.COL_HOLD(4), .DEBOUNCE_SCANS(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .row_n      (row_n),
    .col_n      (col_n),
    .keys       (keys),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .key_strobe (key_strobe)
  );

  always #5 clock = ~clock;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  assign obs = {keys, startn, stopn, clearn};

  always @(negedge clock) begin
    if (key_strobe) strobes++;
    if (int'(keys != 10'd0) + int'(!startn) + int'(!stopn) + int'(!clearn) > 1) excl_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_obs(input string tag, input logic [12:0] exp, input int budget);
    int n;
    n = 0;
    while (obs !== exp && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(obs), 32'(exp));
  endtask

  task automatic hold_steady(input string tag, input logic [12:0] exp, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (obs !== exp) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic press_release(input string tag, input int idx, input logic [12:0] exp);
    int s0;
    s0 = strobes;
    pressed = '0;
    pressed[idx] = 1'b1;
    wait_obs({tag, " press"}, exp, 54);
    hold_steady({tag, " held"}, exp, 8);
    pressed = '0;
    wait_obs({tag, " release"}, IDLE, 54);
    check({tag, " strobes"}, 32'(strobes - s0), 32'd1);
    tick(10);
  endtask

  task automatic idle_press(input string tag, input logic [15:0] keyset, input int cycles);
    int s0;
    s0 = strobes;
    pressed = keyset;
    hold_steady({tag, " idle"}, IDLE, cycles);
    pressed = '0;
    tick(40);
    check({tag, " strobes"}, 32'(strobes - s0), 32'd0);
  endtask

  initial begin
    int s0, n;
    clock = 1'b0;
    reset = 1'b0;
    pressed = '0;
    n_checks = 0;
    n_fails = 0;
    strobes = 0;
    excl_bad = 0;

    #2 reset = 1'b1;
    #1;
    check("reset outputs", 32'(obs), 32'(IDLE));
    check("reset col_n", 32'(col_n), 32'h0000000E);
    check("reset strobe", 32'(key_strobe), 32'd0);
    tick(3);
    reset = 1'b0;

    // Column rotation and scan period.
    n = 0;
    while (col_n !== 4'b1101 && n < 20) begin tick(1); n++; end
    check("col1 reached", 32'(col_n), 32'h0000000D);
    tick(4);
    check("col2 drive", 32'(col_n), 32'h0000000B);
    tick(4);
    check("col3 drive", 32'(col_n), 32'h00000007);
    tick(4);
    check("col0 drive", 32'(col_n), 32'h0000000E);
    tick(10);

    press_release("key5", 5, {10'b0000100000, 3'b111});
    press_release("key1", 0, {10'b0000000010, 3'b111});
    press_release("key0", 13, {10'b0000000001, 3'b111});
    press_release("key5b", 5, {10'b0000100000, 3'b111});
    press_release("start", 3, {10'b0, 3'b011});
    press_release("stop", 7, {10'b0, 3'b101});
    press_release("clear", 11, {10'b0, 3'b110});

    // Direct key-to-key change, 1 then 2.
    s0 = strobes;
    pressed = 16'h0001;
    wait_obs("chg key1", {10'b0000000010, 3'b111}, 54);
    pressed = 16'h0002;
    wait_obs("chg key2", {10'b0000000100, 3'b111}, 54);
    pressed = '0;
    wait_obs("chg release", IDLE, 54);
    check("chg strobes", 32'(strobes - s0), 32'd2);
    tick(10);

    idle_press("multi 3+7", 16'h0104, 80);
    idle_press("multi 1+4", 16'h0011, 60);
    idle_press("ignored *#D", 16'hD000, 60);

    // Bouncy '8' (row2, col1).
    s0 = strobes;
    for (int i = 0; i < 20; i++) begin
      pressed = '0;
      pressed[9] = ((i / 3) % 2 == 0);
      tick(1);
    end
    pressed = '0;
    pressed[9] = 1'b1;
    wait_obs("bounce8 press", {10'b0100000000, 3'b111}, 54);
    hold_steady("bounce8 held", {10'b0100000000, 3'b111}, 8);
    pressed = '0;
    wait_obs("bounce8 release", IDLE, 54);
    check("bounce8 strobes", 32'(strobes - s0), 32'd1);
    tick(10);

    // Reset in the middle of a scan with '5' held.
    pressed = '0;
    pressed[5] = 1'b1;
    wait_obs("rst key5 press", {10'b0000100000, 3'b111}, 54);
    tick(5);
    #3;
    s0 = strobes;
    reset = 1'b1;
    #1;
    check("midrst outputs", 32'(obs), 32'(IDLE));
    check("midrst col_n", 32'(col_n), 32'h0000000E);
    check("midrst strobe", 32'(key_strobe), 32'd0);
    pressed = '0;
    tick(4);
    check("midrst no strobe", 32'(strobes - s0), 32'd0);
    reset = 1'b0;
    hold_steady("post rst idle", IDLE, 40);

    check("exclusive outputs", 32'(excl_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
